rv32i_fetch_queue: RTL and testbench

Parametrised instruction prefetch unit for the rv32i core. It sits between the shared instruction/data memory port and the microcoded control unit. It streams instructions ahead of execution into a halfword queue, so that a non-branching instruction needs no dedicated fetch micro-steps. It supports 16- or 32-bit memory buses and configurable queue depth, and flushes on any control-flow redirect.

---
 rtl/rv32i_fetch_queue_pkg.sv | 30 +++
 rtl/rv32i_fetch_queue_halfword_fifo.sv | 53 +++++
 rtl/rv32i_fetch_queue.sv | 99 +++++++++
 tb/tb_rv32i_fetch_queue.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_fetch_queue_pkg.sv
// Shared rv32i definitions: opcode encodings, halfword width and bus legality/byte-lane helpers.
// Imported by the fetch queue and its halfword FIFO.
package rv32i_fetch_queue_pkg;

   localparam int HW_BITS = 16;

   typedef enum logic [6:0] {
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_BRANCH = 7'b1100011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_IMM    = 7'b0010011,
      OP_REG    = 7'b0110011,
      OP_FENCE  = 7'b0001111,
      OP_SYSTEM = 7'b1110011
   } rv32i_opcode_e;

   function automatic logic bus_bits_legal(input int bits);
      return (bits == 16) || (bits == 32);
   endfunction

   // Memory lanes carry the lower-addressed byte in the upper half.
   function automatic logic [15:0] bswap16(input logic [15:0] h);
      return {h[7:0], h[15:8]};
   endfunction

endpackage

// File: rtl/rv32i_fetch_queue_halfword_fifo.sv
// Halfword circular queue: push W halfwords, pop 2, synchronous clear; data visible the cycle after push.
// No internal flow control: the owner guarantees it never pushes past DEPTH or pops below 2.
module halfword_fifo
   import rv32i_fetch_queue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = 1,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic                    i_clk,
   input  logic                    i_clr,
   input  logic                    i_push,
   input  logic [HW_BITS*W-1:0]    i_push_dat,
   input  logic                    i_pop,
   output logic [HW_BITS-1:0]      o_lo,
   output logic [HW_BITS-1:0]      o_hi,
   output logic [LW-1:0]           o_level
);

   logic [HW_BITS-1:0] r_mem [DEPTH];
   logic [AW-1:0]      r_wr;
   logic [AW-1:0]      r_rd;
   logic [LW-1:0]      r_level;
   logic [AW-1:0]      w_rd_next;

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + AW'(W);
         if (i_pop)  r_rd <= r_rd + AW'(2);
         r_level <= r_level + (i_push ? LW'(W) : LW'(0)) - (i_pop ? LW'(2) : LW'(0));
      end
   end

   // Pointers are AW bits wide, so DEPTH being a power of two gives the wrap for free.
   always_ff @(posedge i_clk) begin
      if (i_push && !i_clr) begin
         for (int k = 0; k < W; k++) begin
            r_mem[r_wr + AW'(k)] <= i_push_dat[HW_BITS*k +: HW_BITS];
         end
      end
   end

   assign w_rd_next = r_rd + AW'(1);
   assign o_lo      = r_mem[r_rd];
   assign o_hi      = r_mem[w_rd_next];
   assign o_level   = r_level;

endmodule

// File: rtl/rv32i_fetch_queue.sv
// Instruction prefetch: streams halfwords ahead of execution; first instruction 3 (32-bit bus) or 4 (16-bit) cycles after redirect.
// Requests only while the queue plus in-flight data still fits, so a stalled consumer never overflows it.
module rv32i_fetch_queue
   import rv32i_fetch_queue_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter int              BUS_BITS     = 16,
   parameter int              DEPTH        = 8,
   parameter logic [XLEN-1:0] INITIAL_ADDR = '0,
   localparam int             LW           = $clog2(DEPTH) + 1
) (
   input  logic                clk_i,
   input  logic                reset_i,
   output logic [XLEN-1:0]     memory_addr_o,
   output logic                memory_read_o,
   input  logic                memory_grant_i,
   input  logic [BUS_BITS-1:0] memory_i,
   input  logic                redirect_i,
   input  logic [XLEN-1:0]     redirect_pc_i,
   output logic                instr_valid_o,
   output logic [31:0]         instr_o,
   output logic [XLEN-1:0]     instr_pc_o,
   input  logic                instr_ready_i,
   output logic [LW-1:0]       level_o
);

   localparam int              W          = BUS_BITS / HW_BITS;
   localparam logic [XLEN-1:0] FETCH_STEP = XLEN'(BUS_BITS / 8);
   localparam logic [LW:0]     W_L        = (LW+1)'(W);
   localparam logic [LW:0]     DEPTH_L    = (LW+1)'(DEPTH);

   if (!bus_bits_legal(BUS_BITS)) begin : g_bad_bus
      $error("rv32i_fetch_queue: BUS_BITS must be 16 or 32");
   end

   logic [XLEN-1:0]     r_fetch_pc;
   logic [XLEN-1:0]     r_out_pc;
   logic                r_inflight;
   logic [LW-1:0]       w_level;
   logic [LW:0]         w_need;
   logic [HW_BITS-1:0]  w_hw_lo;
   logic [HW_BITS-1:0]  w_hw_hi;
   logic [BUS_BITS-1:0] w_push_dat;
   logic [XLEN-1:0]     w_redirect_pc;
   logic                w_clr;
   logic                w_accept;
   logic                w_push;
   logic                w_pop;

   for (genvar k = 0; k < W; k++) begin : g_lane
      assign w_push_dat[HW_BITS*k +: HW_BITS] = bswap16(memory_i[HW_BITS*k +: HW_BITS]);
   end

   // r_inflight marks that memory_i carries our data this cycle; a flush simply refuses to push it.
   assign w_clr         = reset_i | redirect_i;
   assign w_push        = r_inflight & ~w_clr;
   assign w_need        = {1'b0, w_level} + (r_inflight ? W_L + W_L : W_L);
   assign memory_read_o = ~reset_i & ~redirect_i & (w_need <= DEPTH_L);
   assign w_accept      = memory_read_o & memory_grant_i;
   assign instr_valid_o = ~reset_i & (w_level >= LW'(2));
   assign w_pop         = instr_valid_o & instr_ready_i & ~redirect_i;
   assign w_redirect_pc = redirect_pc_i & ~XLEN'(3);

   assign memory_addr_o = reset_i ? INITIAL_ADDR : r_fetch_pc;
   assign level_o       = reset_i ? '0 : w_level;
   assign instr_o       = {w_hw_hi, w_hw_lo};
   assign instr_pc_o    = r_out_pc;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_fetch_pc <= INITIAL_ADDR;
         r_out_pc   <= INITIAL_ADDR;
         r_inflight <= 1'b0;
      end else if (redirect_i) begin
         r_fetch_pc <= w_redirect_pc;
         r_out_pc   <= w_redirect_pc;
         r_inflight <= 1'b0;
      end else begin
         if (w_accept) r_fetch_pc <= r_fetch_pc + FETCH_STEP;
         if (w_pop)    r_out_pc   <= r_out_pc + XLEN'(4);
         r_inflight <= w_accept;
      end
   end

   halfword_fifo #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_fifo (
      .i_clk      (clk_i),
      .i_clr      (w_clr),
      .i_push     (w_push),
      .i_push_dat (w_push_dat),
      .i_pop      (w_pop),
      .o_lo       (w_hw_lo),
      .o_hi       (w_hw_hi),
      .o_level    (w_level)
   );

endmodule

// File: tb/tb_rv32i_fetch_queue.sv
// Drives a 32-bit-bus and a 16-bit-bus fetch queue with shared control and checks both
// against a count-and-address model plus a fixed memory image.
module tb_rv32i_fetch_queue;

   localparam int          DEPTH = 8;
   localparam logic [31:0] INIT  = 32'h0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, redir, grant, ready;
   logic [31:0] rpc;
   logic [31:0] mem_dat [2];
   logic        read_o  [2];
   logic [31:0] addr_o  [2];
   logic        vld_o   [2];
   logic [31:0] instr_o [2];
   logic [31:0] pc_o    [2];
   logic [3:0]  lvl_o   [2];

   rv32i_fetch_queue #(.XLEN(32), .BUS_BITS(32), .DEPTH(DEPTH), .INITIAL_ADDR(INIT)) u_bus32 (
      .clk_i(clk), .reset_i(rst), .memory_addr_o(addr_o[0]), .memory_read_o(read_o[0]),
      .memory_grant_i(grant), .memory_i(mem_dat[0]), .redirect_i(redir), .redirect_pc_i(rpc),
      .instr_valid_o(vld_o[0]), .instr_o(instr_o[0]), .instr_pc_o(pc_o[0]),
      .instr_ready_i(ready), .level_o(lvl_o[0]));

   rv32i_fetch_queue #(.XLEN(32), .BUS_BITS(16), .DEPTH(DEPTH), .INITIAL_ADDR(INIT)) u_bus16 (
      .clk_i(clk), .reset_i(rst), .memory_addr_o(addr_o[1]), .memory_read_o(read_o[1]),
      .memory_grant_i(grant), .memory_i(mem_dat[1][15:0]), .redirect_i(redir), .redirect_pc_i(rpc),
      .instr_valid_o(vld_o[1]), .instr_o(instr_o[1]), .instr_pc_o(pc_o[1]),
      .instr_ready_i(ready), .level_o(lvl_o[1]));

   int checks   = 0;
   int failures = 0;

   // Reference model: halfwords queued, fetch/consume addresses, one outstanding access.
   int          m_lvl [2];
   int          m_inf [2];
   logic [31:0] m_fpc [2];
   logic [31:0] m_opc [2];
   // Memory environment: response owed next cycle.
   bit          pend_vld  [2];
   logic [31:0] pend_addr [2];

   // Raw memory image as seen on a 16-bit lane; 0x00..0x1F holds NOPs (0x00000013).
   function automatic logic [15:0] hw_raw(input logic [31:0] a);
      logic [31:0] t;
      if (a < 32'h20) return a[1] ? 16'h0000 : 16'h1300;
      t = a * 32'h9E3779B1;
      return t[31:16] ^ t[15:0];
   endfunction

   function automatic logic [15:0] swp(input logic [15:0] h);
      return {h[7:0], h[15:8]};
   endfunction

   function automatic logic [31:0] instr_at(input logic [31:0] a);
      return {swp(hw_raw(a + 32'd2)), swp(hw_raw(a))};
   endfunction

   function automatic logic [31:0] bus_word(input int i, input logic [31:0] a);
      if (i == 0) return {hw_raw(a + 32'd2), hw_raw(a)};
      return {16'h0000, hw_raw(a)};
   endfunction

   task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want)
      else begin
         failures++;
         $error("FAIL %s bus%0d: got %h expected %h", tag, (i == 0) ? 32 : 16, obs, want);
      end
   endtask

   // One clock: present memory data, check outputs at negedge, advance the model, return at posedge+1.
   task automatic cycle();
      int w;
      bit e_read, e_valid, acc;
      for (int i = 0; i < 2; i++)
         mem_dat[i] = pend_vld[i] ? bus_word(i, pend_addr[i]) : $urandom();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         w       = (i == 0) ? 2 : 1;
         e_read  = !rst && !redir && (m_lvl[i] + w * m_inf[i] + w <= DEPTH);
         e_valid = !rst && (m_lvl[i] >= 2);
         chk("memory_read_o", i, read_o[i], e_read);
         chk("memory_addr_o", i, addr_o[i], rst ? INIT : m_fpc[i]);
         chk("level_o", i, lvl_o[i], rst ? 0 : m_lvl[i]);
         chk("instr_valid_o", i, vld_o[i], e_valid);
         if (e_valid) begin
            chk("instr_o", i, instr_o[i], instr_at(m_opc[i]));
            chk("instr_pc_o", i, pc_o[i], m_opc[i]);
         end
         pend_vld[i]  = read_o[i] && grant;
         pend_addr[i] = addr_o[i];
         acc = e_read && grant;
         if (rst) begin
            m_lvl[i] = 0; m_inf[i] = 0; m_fpc[i] = INIT; m_opc[i] = INIT;
         end else if (redir) begin
            m_lvl[i] = 0; m_inf[i] = 0; m_fpc[i] = rpc & ~32'h3; m_opc[i] = rpc & ~32'h3;
         end else begin
            if (m_inf[i] != 0) m_lvl[i] += w;
            if (e_valid && ready) begin
               m_lvl[i] -= 2;
               m_opc[i] += 32'd4;
            end
            if (acc) m_fpc[i] += 32'(2 * w);
            m_inf[i] = acc ? 1 : 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; redir = 1'b0; rpc = 32'h0; grant = 1'b1; ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         m_lvl[i] = 0; m_inf[i] = 0; m_fpc[i] = INIT; m_opc[i] = INIT;
         pend_vld[i] = 1'b0; pend_addr[i] = 32'h0; mem_dat[i] = 32'h0;
      end
      @(posedge clk);
      #1;

      // Reset cycles, then release and stream NOPs.
      repeat (2) cycle();
      rst = 1'b0;
      cycle();
      cycle();
      chk("first_valid", 0, vld_o[0], 1'b1);
      chk("first_instr", 0, instr_o[0], 32'h0000_0013);
      chk("first_pc", 0, pc_o[0], 32'h0);
      repeat (20) cycle();

      // Consumer stalls: both queues fill to DEPTH and stop requesting.
      ready = 1'b0;
      repeat (20) cycle();
      chk("full_level", 0, lvl_o[0], 4'd8);
      chk("full_level", 1, lvl_o[1], 4'd8);
      chk("full_noreq", 0, read_o[0], 1'b0);
      chk("full_noreq", 1, read_o[1], 1'b0);
      ready = 1'b1;
      cycle();
      ready = 1'b0;
      chk("resume_req", 0, read_o[0], 1'b1);
      chk("resume_req", 1, read_o[1], 1'b1);
      repeat (3) cycle();
      ready = 1'b1;
      repeat (6) cycle();

      // Redirect right after an accepted 32-bit request: its data must be dropped.
      for (int n = 0; n < 20 && !pend_vld[0]; n++) cycle();
      chk("redir_setup", 0, pend_vld[0], 1'b1);
      redir = 1'b1; rpc = 32'h100;
      cycle();
      redir = 1'b0;
      chk("redir_level", 0, lvl_o[0], 4'd0);
      chk("redir_level", 1, lvl_o[1], 4'd0);
      cycle();
      cycle();
      chk("redir_valid", 0, vld_o[0], 1'b1);
      chk("redir_pc", 0, pc_o[0], 32'h100);
      repeat (4) cycle();

      // Grant alternating every cycle.
      for (int n = 0; n < 40; n++) begin
         grant = n[0];
         ready = 1'($urandom_range(0, 1));
         cycle();
      end
      grant = 1'b1; ready = 1'b0;

      // Reset with level 6 and an access in flight (32-bit bus).
      redir = 1'b1; rpc = 32'h200;
      cycle();
      redir = 1'b0;
      repeat (4) cycle();
      chk("pre_reset_level", 0, lvl_o[0], 4'd6);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("post_reset_level", 0, lvl_o[0], 4'd0);
      chk("post_reset_valid", 0, vld_o[0], 1'b0);
      chk("post_reset_addr", 0, addr_o[0], INIT);
      ready = 1'b1;
      repeat (6) cycle();

      // Randomised traffic.
      for (int n = 0; n < 3000; n++) begin
         rst   = ($urandom_range(0, 99) == 0);
         redir = !rst && ($urandom_range(0, 29) == 0);
         rpc   = $urandom();
         grant = ($urandom_range(0, 3) != 0);
         ready = ($urandom_range(0, 9) < 7);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
